// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1-style UART transmitter with integer baud divider
//
// Serialises one DATA_BITS-wide word per accepted request, LSB first:
// one start bit (0), DATA_BITS data bits, one stop bit (1), no parity.
// Every bit lasts CLKS_PER_BIT = SYS_CLK / BAUD clock cycles.
//
// Ports:
//   clk       in   system clock, rising-edge active
//   rst       in   asynchronous active-high reset
//   enable    in   block enable; low aborts any frame and holds idle
//   tx_input  in   word to transmit, sampled only when a frame is accepted
//   new_data  in   level-sensitive transmit request
//   tx_wire   out  registered serial line, idle/mark = 1
//   ready     out  high when a request would be accepted this cycle

module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int BAUD      = 9600,
    parameter int SYS_CLK   = 12000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] tx_input,
    input  logic                 new_data,
    output logic                 tx_wire,
    output logic                 ready
);

    localparam int CLKS_PER_BIT = SYS_CLK / BAUD;

    // Degenerate one-cycle bits or one-bit words still need a 1-bit counter.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]           state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 bit_done;

    // Last cycle of the current bit period.
    assign bit_done   = (baud_cnt == BAUD_LAST);
    assign shift_next = shift_reg >> 1;

    // Decoded from registered state only; enable is the sole input that
    // reaches ready combinationally.
    assign ready = enable && (state == S_IDLE);

    // tx_wire is registered alongside the state so the line changes exactly
    // on the edge that starts each bit and cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tx_wire   <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else if (!enable) begin
            // Abort: the frame in progress is dropped, not completed.
            state    <= S_IDLE;
            tx_wire  <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_wire <= 1'b1;
                    if (new_data) begin
                        shift_reg <= tx_input;
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        state     <= S_START;
                        tx_wire   <= 1'b0;
                    end
                end

                S_START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                        tx_wire  <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_next;
                        if (bit_idx == BIT_LAST) begin
                            state   <= S_STOP;
                            tx_wire <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            // Drive the bit that the shift is about to expose.
                            tx_wire <= shift_next[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (bit_done) begin
                        // Returning to IDLE here raises ready on the edge that
                        // ends the stop bit; a held request restarts one cycle
                        // later.
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                        tx_wire  <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    tx_wire <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx

module tb_uart_tx;

    localparam int DB      = 8;
    localparam int T_BAUD  = 7;
    localparam int T_CLK   = 100;
    localparam int CPB     = T_CLK / T_BAUD;   // 14 after truncation
    localparam int FRAME   = (DB + 2) * CPB;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [DB-1:0] tx_input;
    logic          new_data;
    logic          tx_wire;
    logic          ready;

    uart_tx #(
        .DATA_BITS (DB),
        .BAUD      (T_BAUD),
        .SYS_CLK   (T_CLK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .tx_input (tx_input),
        .new_data (new_data),
        .tx_wire  (tx_wire),
        .ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a frame is just "busy since accept, t cycles in";
    // the line value follows from which bit period t falls into.
    logic          m_busy = 1'b0;
    int            m_t    = 0;
    logic [DB-1:0] m_data = '0;

    function automatic logic exp_line();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k <= DB) return m_data[k-1];
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 unit later.
    task automatic step(input logic en, input logic nd, input logic [DB-1:0] din);
        enable   = en;
        new_data = nd;
        tx_input = din;
        @(posedge clk);
        cyc++;
        if (!en) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (nd) begin
                m_busy = 1'b1;
                m_t    = 0;
                m_data = din;
            end
        end else begin
            m_t++;
            if (m_t == FRAME) m_busy = 1'b0;
        end
        #1;
        check("model_tx", {31'd0, tx_wire}, {31'd0, exp_line()});
        check("model_ready", {31'd0, ready}, {31'd0, en && !m_busy});
    endtask

    // Send one frame; tx_input is scrambled after the accept edge to show it
    // is not re-sampled mid-frame.
    task automatic run_frame(input logic [DB-1:0] data, input logic [9:0] exp_bits, input logic hold);
        logic [9:0] got;
        int         low_ready;
        got       = '0;
        low_ready = 0;
        for (int o = 0; o < FRAME; o++) begin
            if (o == 0) step(1'b1, 1'b1, data);
            else        step(1'b1, hold, DB'($urandom));
            if (o % CPB == CPB / 2) got[o / CPB] = tx_wire;
            if (ready == 1'b0) low_ready++;
        end
        check("frame_bits", {22'd0, got}, {22'd0, exp_bits});
        check("ready_low_cycles", low_ready, FRAME);
        step(1'b1, hold, DB'($urandom));
        check("gap_tx", {31'd0, tx_wire}, 32'd1);
        check("gap_ready", {31'd0, ready}, 32'd1);
    endtask

    typedef struct {
        logic [DB-1:0] data;
        logic          hold;
        logic [9:0]    bits;   // bits[0] is the first bit on the line
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{data: 8'h00, hold: 1'b0, bits: 10'b10_0000_0000};
        vecs[1] = '{data: 8'h81, hold: 1'b0, bits: 10'b11_0000_0010};
        vecs[2] = '{data: 8'hA5, hold: 1'b1, bits: 10'b11_0100_1010};
        vecs[3] = '{data: 8'hA5, hold: 1'b0, bits: 10'b11_0100_1010};

        rst      = 1'b1;
        enable   = 1'b0;
        new_data = 1'b0;
        tx_input = '0;
        #2;
        check("reset_tx", {31'd0, tx_wire}, 32'd1);
        check("reset_ready_en0", {31'd0, ready}, 32'd0);
        enable = 1'b1;
        #1;
        check("reset_ready_en1", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Idle with undefined data: line must stay at mark.
        for (int i = 0; i < 10 * CPB; i++) begin
            step(1'b1, 1'b0, 'x);
            if (i % CPB == CPB / 2) begin
                check("idle_tx", {31'd0, tx_wire}, 32'd1);
                check("idle_ready", {31'd0, ready}, 32'd1);
            end
        end

        for (int v = 0; v < 4; v++) run_frame(vecs[v].data, vecs[v].bits, vecs[v].hold);

        // Abort during data bit 3 (frame bit 4); 0x55 has a 0 there.
        step(1'b1, 1'b1, 8'h55);
        for (int o = 1; o <= 4 * CPB + 2; o++) step(1'b1, 1'b0, 8'h55);
        check("abort_pre_tx", {31'd0, tx_wire}, 32'd0);
        step(1'b0, 1'b0, 8'h55);
        check("abort_tx", {31'd0, tx_wire}, 32'd1);
        check("abort_ready", {31'd0, ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h12);
            check("disabled_ready", {31'd0, ready}, 32'd0);
            check("disabled_tx", {31'd0, tx_wire}, 32'd1);
        end
        step(1'b1, 1'b0, 8'h00);
        check("reenable_ready", {31'd0, ready}, 32'd1);
        check("reenable_tx", {31'd0, tx_wire}, 32'd1);

        // Asynchronous reset in the middle of data bit 0 of 0xF0.
        step(1'b1, 1'b1, 8'hF0);
        for (int o = 1; o <= CPB + 3; o++) step(1'b1, 1'b0, 8'hF0);
        check("rst_pre_tx", {31'd0, tx_wire}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx", {31'd0, tx_wire}, 32'd1);
        check("async_rst_ready", {31'd0, ready}, 32'd1);
        m_busy = 1'b0;
        #1;
        rst = 1'b0;
        run_frame(8'h3C, 10'b10_0111_1000, 1'b0);

        // Random traffic with occasional enable drops, checked by the model.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) == 0), DB'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
